// File: rtl/fft_pkg.sv
// Shared widths, latency and fixed-point helpers for the FFT butterfly datapath.
// Helpers work on a wide signed accumulator type so one copy serves every width.
package fft_pkg;

  localparam int DATA_W       = 16;
  localparam int TW_W         = 16;
  localparam int BFLY_LATENCY = 4;

  // Wide enough for a full WIDTH+TW_WIDTH product plus guard bits at 16-bit widths.
  localparam int ACC_W  = 40;
  localparam int WORD_W = 2 * ACC_W;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic        [WORD_W-1:0] word_t;

  localparam acc_t ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

  // Upper half of a packed {re, im} word of 2*w bits, sign-extended.
  function automatic acc_t re_field(input word_t word, input int w);
    acc_t r;
    r = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (i < w) begin
        r[i] = word[w + i];
      end else begin
        r[i] = word[2 * w - 1];
      end
    end
    return r;
  endfunction

  // Lower half of a packed {re, im} word of 2*w bits, sign-extended.
  function automatic acc_t im_field(input word_t word, input int w);
    acc_t r;
    r = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (i < w) begin
        r[i] = word[i];
      end else begin
        r[i] = word[w - 1];
      end
    end
    return r;
  endfunction

  // Arithmetic right shift by sh, rounding half up (adds the last discarded bit's weight).
  function automatic acc_t round_shr(input acc_t x, input int sh);
    acc_t bias;
    bias = '0;
    if (sh > 0) begin
      bias[sh - 1] = 1'b1;
    end else begin
      bias = '0;
    end
    return (x + bias) >>> sh;
  endfunction

  // Clamp to the signed range of a w-bit two's complement number.
  function automatic acc_t sat_to_width(input acc_t x, input int w);
    acc_t hi;
    acc_t lo;
    acc_t r;
    hi        = '0;
    hi[w - 1] = 1'b1;
    lo        = -hi;
    hi        = hi - ACC_ONE;
    if (x > hi) begin
      r = hi;
    end else if (x < lo) begin
      r = lo;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Beat-level handshake bundle of butterfly_pipe: input legs/twiddle/scale and output legs.
interface butterfly_pipe_if
  import fft_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int TW_WIDTH = TW_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic [2*WIDTH-1:0]      a;
  logic [2*WIDTH-1:0]      b;
  logic [2*TW_WIDTH-1:0]   twiddle;
  logic                    scale;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*WIDTH-1:0]      aout;
  logic [2*WIDTH-1:0]      bout;

  modport slave (
    input  in_valid, a, b, twiddle, scale, out_ready,
    output in_ready, out_valid, aout, bout
  );

  modport master (
    output in_valid, a, b, twiddle, scale, out_ready,
    input  in_ready, out_valid, aout, bout
  );

endinterface

// File: rtl/cmult_pipe.sv
// Two-stage pipelined complex multiply b*w: raw partial products, then combine and
// rescale to Q1.(WIDTH-1) in WIDTH+2 bits so that (-1)*(-1) stays representable.
module cmult_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int TW_WIDTH = TW_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [2*WIDTH-1:0]       b,
  input  logic [2*TW_WIDTH-1:0]    w,
  output logic signed [WIDTH+1:0]  p_re,
  output logic signed [WIDTH+1:0]  p_im
);

  localparam int PW = WIDTH + TW_WIDTH;

  acc_t b_re_x;
  acc_t b_im_x;
  acc_t w_re_x;
  acc_t w_im_x;

  logic signed [PW-1:0]    rr_d, rr_q;
  logic signed [PW-1:0]    ii_d, ii_q;
  logic signed [PW-1:0]    ri_d, ri_q;
  logic signed [PW-1:0]    ir_d, ir_q;
  logic signed [PW:0]      sum_re_s;
  logic signed [PW:0]      sum_im_s;
  logic signed [WIDTH+1:0] p_re_d, p_re_q;
  logic signed [WIDTH+1:0] p_im_d, p_im_q;

  // Products and combine; the extra sum bit keeps rr-ii exact before rescaling.
  always_comb begin
    b_re_x   = re_field(word_t'(b), WIDTH);
    b_im_x   = im_field(word_t'(b), WIDTH);
    w_re_x   = re_field(word_t'(w), TW_WIDTH);
    w_im_x   = im_field(word_t'(w), TW_WIDTH);
    sum_re_s = (PW+1)'(rr_q) - (PW+1)'(ii_q);
    sum_im_s = (PW+1)'(ri_q) + (PW+1)'(ir_q);
    if (en) begin
      rr_d   = PW'(b_re_x * w_re_x);
      ii_d   = PW'(b_im_x * w_im_x);
      ri_d   = PW'(b_re_x * w_im_x);
      ir_d   = PW'(b_im_x * w_re_x);
      p_re_d = (WIDTH+2)'(round_shr(acc_t'(sum_re_s), TW_WIDTH - 1));
      p_im_d = (WIDTH+2)'(round_shr(acc_t'(sum_im_s), TW_WIDTH - 1));
    end else begin
      rr_d   = rr_q;
      ii_d   = ii_q;
      ri_d   = ri_q;
      ir_d   = ir_q;
      p_re_d = p_re_q;
      p_im_d = p_im_q;
    end
  end

  // Product and combine stage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q   <= '0;
      ii_q   <= '0;
      ri_q   <= '0;
      ir_q   <= '0;
      p_re_q <= '0;
      p_im_q <= '0;
    end else begin
      rr_q   <= rr_d;
      ii_q   <= ii_d;
      ri_q   <= ri_d;
      ir_q   <= ir_d;
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end

  assign p_re = p_re_q;
  assign p_im = p_im_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly A' = A + B*W, B' = A - B*W with valid/ready flow
// control, per-beat divide-by-2, saturation and a sticky overflow flag.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int TW_WIDTH = TW_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_ovf,
  butterfly_pipe_if.slave bus,
  output logic            ovf
);

  localparam int DW  = 2 * WIDTH;
  localparam int TWW = 2 * TW_WIDTH;

  logic           adv_s;

  logic           s1_valid_d, s1_valid_q;
  logic [DW-1:0]  s1_a_d, s1_a_q;
  logic [DW-1:0]  s1_b_d, s1_b_q;
  logic [TWW-1:0] s1_w_d, s1_w_q;
  logic           s1_scale_d, s1_scale_q;
  logic           s2_valid_d, s2_valid_q;
  logic [DW-1:0]  s2_a_d, s2_a_q;
  logic           s2_scale_d, s2_scale_q;
  logic           s3_valid_d, s3_valid_q;
  logic [DW-1:0]  s3_a_d, s3_a_q;
  logic           s3_scale_d, s3_scale_q;

  logic signed [WIDTH+1:0] p_re_s;
  logic signed [WIDTH+1:0] p_im_s;

  acc_t           a_re_x;
  acc_t           a_im_x;
  acc_t           raw_x [4];
  acc_t           scl_x [4];
  acc_t           sat_x [4];
  logic           sat_any_s;

  logic           out_valid_d, out_valid_q;
  logic [DW-1:0]  aout_d, aout_q;
  logic [DW-1:0]  bout_d, bout_q;
  logic           ovf_d, ovf_q;

  // One global advance: every stage moves together, bubbles included.
  always_comb begin
    adv_s = !out_valid_q || bus.out_ready;
    if (adv_s) begin
      s1_valid_d = bus.in_valid;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
      s1_w_d     = bus.twiddle;
      s1_scale_d = bus.scale;
      s2_valid_d = s1_valid_q;
      s2_a_d     = s1_a_q;
      s2_scale_d = s1_scale_q;
      s3_valid_d = s2_valid_q;
      s3_a_d     = s2_a_q;
      s3_scale_d = s2_scale_q;
    end else begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_w_d     = s1_w_q;
      s1_scale_d = s1_scale_q;
      s2_valid_d = s2_valid_q;
      s2_a_d     = s2_a_q;
      s2_scale_d = s2_scale_q;
      s3_valid_d = s3_valid_q;
      s3_a_d     = s3_a_q;
      s3_scale_d = s3_scale_q;
    end
  end

  cmult_pipe #(
    .WIDTH    (WIDTH),
    .TW_WIDTH (TW_WIDTH)
  ) u_cmult (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (adv_s),
    .b       (s1_b_q),
    .w       (s1_w_q),
    .p_re    (p_re_s),
    .p_im    (p_im_s)
  );

  // Output stage: sum/difference, optional halving, saturation and the overflow update.
  always_comb begin
    a_re_x    = re_field(word_t'(s3_a_q), WIDTH);
    a_im_x    = im_field(word_t'(s3_a_q), WIDTH);
    raw_x[0]  = a_re_x + acc_t'(p_re_s);
    raw_x[1]  = a_im_x + acc_t'(p_im_s);
    raw_x[2]  = a_re_x - acc_t'(p_re_s);
    raw_x[3]  = a_im_x - acc_t'(p_im_s);
    sat_any_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (s3_scale_q) begin
        scl_x[k] = round_shr(raw_x[k], 32'sd1);
      end else begin
        scl_x[k] = raw_x[k];
      end
      sat_x[k]  = sat_to_width(scl_x[k], WIDTH);
      sat_any_s = sat_any_s | (sat_x[k] != scl_x[k]);
    end

    if (adv_s) begin
      out_valid_d = s3_valid_q;
      aout_d      = {WIDTH'(sat_x[0]), WIDTH'(sat_x[1])};
      bout_d      = {WIDTH'(sat_x[2]), WIDTH'(sat_x[3])};
    end else begin
      out_valid_d = out_valid_q;
      aout_d      = aout_q;
      bout_d      = bout_q;
    end

    // A clear in the same cycle as a saturating beat leaves the flag low.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (adv_s && s3_valid_q && sat_any_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline, output and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_w_q      <= '0;
      s1_scale_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_scale_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_a_q      <= '0;
      s3_scale_q  <= 1'b0;
      out_valid_q <= 1'b0;
      aout_q      <= '0;
      bout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_w_q      <= s1_w_d;
      s1_scale_q  <= s1_scale_d;
      s2_valid_q  <= s2_valid_d;
      s2_a_q      <= s2_a_d;
      s2_scale_q  <= s2_scale_d;
      s3_valid_q  <= s3_valid_d;
      s3_a_q      <= s3_a_d;
      s3_scale_q  <= s3_scale_d;
      out_valid_q <= out_valid_d;
      aout_q      <= aout_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_q;
  assign bus.aout      = aout_q;
  assign bus.bout      = bout_q;
  assign ovf           = ovf_q;

endmodule
